// File: rtl/forwarding_unit_pkg.sv
// forwarding_unit_pkg
// Shared definitions for the operand forwarding unit: register-number width
// and the 2-bit ALU operand select codes.
package forwarding_unit_pkg;

    // Width of an architectural register number (32 registers)
    localparam int REG_W = 5;

    // ALU operand select codes
    localparam logic [1:0] SEL_IMM = 2'b00;  // shamt (A) or immediate (B)
    localparam logic [1:0] SEL_MEM = 2'b01;  // MEM-stage result
    localparam logic [1:0] SEL_EX  = 2'b10;  // EX-stage result
    localparam logic [1:0] SEL_RF  = 2'b11;  // register-file read value

endpackage

// File: rtl/forwarding_unit_if.sv
// forwarding_unit_if
// Bundles the forwarding unit's decode-side request signals and its select
// responses so an environment can carry them around as one object.
//   master : drives the ID/EX/MEM request fields, observes the selects
//   slave  : observes the request fields, drives the selects
interface forwarding_unit_if;
    import forwarding_unit_pkg::*;

    logic             UseShamt;
    logic             UseImmed;
    logic [REG_W-1:0] ID_Rs;
    logic [REG_W-1:0] ID_Rt;
    logic [REG_W-1:0] EX_Rw;
    logic [REG_W-1:0] MEM_Rw;
    logic             EX_RegWrite;
    logic             MEM_RegWrite;
    logic [1:0]       AluOpCtrlA;
    logic [1:0]       AluOpCtrlB;
    logic             DataMemForwardCtrl_EX;
    logic             DataMemForwardCtrl_MEM;
    logic [1:0]       AluOpCtrlA_q;
    logic [1:0]       AluOpCtrlB_q;
    logic             DataMemFwdEX_q;
    logic             DataMemFwdMEM_q;

    modport master (
        output UseShamt, UseImmed, ID_Rs, ID_Rt, EX_Rw, MEM_Rw,
               EX_RegWrite, MEM_RegWrite,
        input  AluOpCtrlA, AluOpCtrlB, DataMemForwardCtrl_EX,
               DataMemForwardCtrl_MEM, AluOpCtrlA_q, AluOpCtrlB_q,
               DataMemFwdEX_q, DataMemFwdMEM_q
    );

    modport slave (
        input  UseShamt, UseImmed, ID_Rs, ID_Rt, EX_Rw, MEM_Rw,
               EX_RegWrite, MEM_RegWrite,
        output AluOpCtrlA, AluOpCtrlB, DataMemForwardCtrl_EX,
               DataMemForwardCtrl_MEM, AluOpCtrlA_q, AluOpCtrlB_q,
               DataMemFwdEX_q, DataMemFwdMEM_q
    );

endinterface

// File: rtl/forwarding_unit_fwd_hit_cmp.sv
// fwd_hit_cmp
// Decides whether one ID-stage source register is being written by the
// instruction currently in EX and/or in MEM.
//   src_i      : source register number
//   ex_rw_i    : EX destination,  ex_we_i  : EX write enable
//   mem_rw_i   : MEM destination, mem_we_i : MEM write enable
//   ex_hit_o   : EX stage produces src_i
//   mem_hit_o  : MEM stage produces src_i
module fwd_hit_cmp
    import forwarding_unit_pkg::*;
(
    input  logic [REG_W-1:0] src_i,
    input  logic [REG_W-1:0] ex_rw_i,
    input  logic [REG_W-1:0] mem_rw_i,
    input  logic             ex_we_i,
    input  logic             mem_we_i,
    output logic             ex_hit_o,
    output logic             mem_hit_o
);

    // Register 0 is hardwired to zero, so a write to it is never a producer.
    assign ex_hit_o  = ex_we_i  && (ex_rw_i  == src_i) && (ex_rw_i  != '0);
    assign mem_hit_o = mem_we_i && (mem_rw_i == src_i) && (mem_rw_i != '0);

endmodule

// File: rtl/forwarding_unit.sv
// forwarding_unit
// Operand forwarding control for a 5-stage pipeline. Produces combinational
// ALU operand selects and store-data forward selects for the ID-stage
// instruction, plus copies of the same four values registered into EX.
//   CLK, Reset_L            : clock (rising edge), async active-low reset
//   UseShamt / UseImmed     : A / B operand comes from shamt / immediate
//   ID_Rs, ID_Rt            : ID-stage source registers
//   EX_Rw, MEM_Rw           : EX / MEM destination registers
//   EX_RegWrite, MEM_RegWrite : EX / MEM write enables
//   AluOpCtrlA/B            : combinational operand selects
//   DataMemForwardCtrl_EX/MEM : combinational store-data selects
//   *_q                     : the four selects above, one cycle later
module forwarding_unit
    import forwarding_unit_pkg::*;
(
    input  logic             CLK,
    input  logic             Reset_L,
    input  logic             UseShamt,
    input  logic             UseImmed,
    input  logic [REG_W-1:0] ID_Rs,
    input  logic [REG_W-1:0] ID_Rt,
    input  logic [REG_W-1:0] EX_Rw,
    input  logic [REG_W-1:0] MEM_Rw,
    input  logic             EX_RegWrite,
    input  logic             MEM_RegWrite,
    output logic [1:0]       AluOpCtrlA,
    output logic [1:0]       AluOpCtrlB,
    output logic             DataMemForwardCtrl_EX,
    output logic             DataMemForwardCtrl_MEM,
    output logic [1:0]       AluOpCtrlA_q,
    output logic [1:0]       AluOpCtrlB_q,
    output logic             DataMemFwdEX_q,
    output logic             DataMemFwdMEM_q
);

    logic rs_ex_hit, rs_mem_hit;
    logic rt_ex_hit, rt_mem_hit;

    fwd_hit_cmp u_rs_cmp (
        .src_i    (ID_Rs),
        .ex_rw_i  (EX_Rw),
        .mem_rw_i (MEM_Rw),
        .ex_we_i  (EX_RegWrite),
        .mem_we_i (MEM_RegWrite),
        .ex_hit_o (rs_ex_hit),
        .mem_hit_o(rs_mem_hit)
    );

    fwd_hit_cmp u_rt_cmp (
        .src_i    (ID_Rt),
        .ex_rw_i  (EX_Rw),
        .mem_rw_i (MEM_Rw),
        .ex_we_i  (EX_RegWrite),
        .mem_we_i (MEM_RegWrite),
        .ex_hit_o (rt_ex_hit),
        .mem_hit_o(rt_mem_hit)
    );

    // Priority: shamt/immediate, then the younger EX result, then MEM.
    always_comb begin
        AluOpCtrlA = SEL_RF;
        if (UseShamt)        AluOpCtrlA = SEL_IMM;
        else if (rs_ex_hit)  AluOpCtrlA = SEL_EX;
        else if (rs_mem_hit) AluOpCtrlA = SEL_MEM;

        AluOpCtrlB = SEL_RF;
        if (UseImmed)        AluOpCtrlB = SEL_IMM;
        else if (rt_ex_hit)  AluOpCtrlB = SEL_EX;
        else if (rt_mem_hit) AluOpCtrlB = SEL_MEM;
    end

    // Store data always comes through Rt, even when B takes the immediate.
    // The naming pairs each control with the downstream stage that consumes
    // it, so an EX hit raises the _MEM control and vice versa.
    assign DataMemForwardCtrl_MEM = rt_ex_hit;
    assign DataMemForwardCtrl_EX  = rt_mem_hit && !rt_ex_hit;

    // ID -> EX stage registers
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            AluOpCtrlA_q    <= SEL_RF;
            AluOpCtrlB_q    <= SEL_RF;
            DataMemFwdEX_q  <= 1'b0;
            DataMemFwdMEM_q <= 1'b0;
        end else begin
            AluOpCtrlA_q    <= AluOpCtrlA;
            AluOpCtrlB_q    <= AluOpCtrlB;
            DataMemFwdEX_q  <= DataMemForwardCtrl_EX;
            DataMemFwdMEM_q <= DataMemForwardCtrl_MEM;
        end
    end

endmodule

// File: tb/tb_forwarding_unit.sv
module tb_forwarding_unit;

    logic CLK;
    logic Reset_L;

    forwarding_unit_if fif ();

    forwarding_unit dut (
        .CLK                   (CLK),
        .Reset_L               (Reset_L),
        .UseShamt              (fif.UseShamt),
        .UseImmed              (fif.UseImmed),
        .ID_Rs                 (fif.ID_Rs),
        .ID_Rt                 (fif.ID_Rt),
        .EX_Rw                 (fif.EX_Rw),
        .MEM_Rw                (fif.MEM_Rw),
        .EX_RegWrite           (fif.EX_RegWrite),
        .MEM_RegWrite          (fif.MEM_RegWrite),
        .AluOpCtrlA            (fif.AluOpCtrlA),
        .AluOpCtrlB            (fif.AluOpCtrlB),
        .DataMemForwardCtrl_EX (fif.DataMemForwardCtrl_EX),
        .DataMemForwardCtrl_MEM(fif.DataMemForwardCtrl_MEM),
        .AluOpCtrlA_q          (fif.AluOpCtrlA_q),
        .AluOpCtrlB_q          (fif.AluOpCtrlB_q),
        .DataMemFwdEX_q        (fif.DataMemFwdEX_q),
        .DataMemFwdMEM_q       (fif.DataMemFwdMEM_q)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Directed vector: inputs plus hand-computed combinational response
    typedef struct {
        logic       sh, im;
        logic [4:0] rs, rt, exrw, memrw;
        logic       exwe, memwe;
        logic [1:0] a, b;
        logic       dex, dmem;
    } vec_t;

    // Scoreboard item: expected combinational and registered outputs
    typedef struct {
        int         id;
        logic [1:0] a, b;
        logic       dex, dmem;
        logic [1:0] qa, qb;
        logic       qdex, qdmem;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[$];
    int   vectors = 0;
    int   miscompares = 0;

    logic [1:0] prev_a, prev_b;
    logic       prev_dex, prev_dmem;

    task automatic apply(input vec_t v, input logic rst_val);
        exp_t e;
        logic rst_at_edge;
        @(posedge CLK);
        rst_at_edge = !Reset_L;
        #1;
        Reset_L          = rst_val;
        fif.UseShamt     = v.sh;
        fif.UseImmed     = v.im;
        fif.ID_Rs        = v.rs;
        fif.ID_Rt        = v.rt;
        fif.EX_Rw        = v.exrw;
        fif.MEM_Rw       = v.memrw;
        fif.EX_RegWrite  = v.exwe;
        fif.MEM_RegWrite = v.memwe;
        e.id   = vectors + exp_q.size();
        e.a    = v.a;  e.b = v.b;  e.dex = v.dex;  e.dmem = v.dmem;
        if (rst_at_edge || !rst_val) begin
            e.qa = 2'b11; e.qb = 2'b11; e.qdex = 1'b0; e.qdmem = 1'b0;
        end else begin
            e.qa = prev_a; e.qb = prev_b; e.qdex = prev_dex; e.qdmem = prev_dmem;
        end
        exp_q.push_back(e);
        prev_a = v.a; prev_b = v.b; prev_dex = v.dex; prev_dmem = v.dmem;
    endtask

    // Monitor: mid-cycle, pop the expectation for the vector now applied
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (fif.AluOpCtrlA !== e.a || fif.AluOpCtrlB !== e.b ||
                    fif.DataMemForwardCtrl_EX !== e.dex ||
                    fif.DataMemForwardCtrl_MEM !== e.dmem) begin
                    miscompares++;
                    $display("FAIL v%0d comb: got A=%b B=%b dEX=%b dMEM=%b, expected A=%b B=%b dEX=%b dMEM=%b",
                             e.id, fif.AluOpCtrlA, fif.AluOpCtrlB,
                             fif.DataMemForwardCtrl_EX, fif.DataMemForwardCtrl_MEM,
                             e.a, e.b, e.dex, e.dmem);
                end
                if (fif.AluOpCtrlA_q !== e.qa || fif.AluOpCtrlB_q !== e.qb ||
                    fif.DataMemFwdEX_q !== e.qdex || fif.DataMemFwdMEM_q !== e.qdmem) begin
                    miscompares++;
                    $display("FAIL v%0d regd: got A_q=%b B_q=%b EX_q=%b MEM_q=%b, expected A_q=%b B_q=%b EX_q=%b MEM_q=%b",
                             e.id, fif.AluOpCtrlA_q, fif.AluOpCtrlB_q,
                             fif.DataMemFwdEX_q, fif.DataMemFwdMEM_q,
                             e.qa, e.qb, e.qdex, e.qdmem);
                end
            end
        end
    end

    function automatic vec_t mk(logic sh, logic im, logic [4:0] rs, logic [4:0] rt,
                                logic [4:0] exrw, logic [4:0] memrw,
                                logic exwe, logic memwe,
                                logic [1:0] a, logic [1:0] b, logic dex, logic dmem);
        vec_t v;
        v.sh = sh; v.im = im; v.rs = rs; v.rt = rt; v.exrw = exrw; v.memrw = memrw;
        v.exwe = exwe; v.memwe = memwe; v.a = a; v.b = b; v.dex = dex; v.dmem = dmem;
        return v;
    endfunction

    initial begin
        int budget;
        Reset_L          = 1'b0;
        fif.UseShamt     = 1'b0;
        fif.UseImmed     = 1'b0;
        fif.ID_Rs        = '0;
        fif.ID_Rt        = '0;
        fif.EX_Rw        = '0;
        fif.MEM_Rw       = '0;
        fif.EX_RegWrite  = 1'b0;
        fif.MEM_RegWrite = 1'b0;
        prev_a = 2'b11; prev_b = 2'b11; prev_dex = 1'b0; prev_dmem = 1'b0;

        //            sh im  rs  rt exrw memrw exwe memwe   A      B    dEX dMEM
        vecs.push_back(mk(0, 0,  3,  5,  5,  2, 0, 1, 2'b11, 2'b11, 0, 0));
        vecs.push_back(mk(0, 0,  3,  5,  5,  2, 1, 1, 2'b11, 2'b10, 0, 1));
        vecs.push_back(mk(0, 0,  3,  5,  1,  5, 1, 1, 2'b11, 2'b01, 1, 0));
        vecs.push_back(mk(0, 0,  5,  3,  1,  5, 1, 1, 2'b01, 2'b11, 0, 0));
        vecs.push_back(mk(0, 0,  0,  0,  0,  0, 1, 0, 2'b11, 2'b11, 0, 0));
        vecs.push_back(mk(0, 0,  0,  0,  0,  0, 0, 1, 2'b11, 2'b11, 0, 0));
        vecs.push_back(mk(1, 1,  5,  4,  5,  4, 1, 1, 2'b00, 2'b00, 1, 0));
        vecs.push_back(mk(0, 0,  7,  7,  7,  7, 1, 1, 2'b10, 2'b10, 0, 1));
        vecs.push_back(mk(0, 1,  2,  9,  9,  2, 1, 1, 2'b01, 2'b00, 0, 1));
        vecs.push_back(mk(1, 0,  6,  6,  6,  0, 1, 1, 2'b00, 2'b10, 0, 1));
        vecs.push_back(mk(0, 0, 31, 30, 31, 30, 0, 0, 2'b11, 2'b11, 0, 0));
        vecs.push_back(mk(0, 0, 31, 30, 30, 31, 1, 1, 2'b01, 2'b10, 0, 1));

        // Reset held across the first two vectors: registers stay at reset
        apply(vecs[0], 1'b0);
        apply(vecs[1], 1'b0);
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], 1'b1);
        // Mid-operation reset pulse, then release and recapture
        apply(vecs[7], 1'b0);
        apply(vecs[11], 1'b1);
        apply(vecs[2], 1'b1);
        apply(vecs[6], 1'b1);
        apply(vecs[9], 1'b1);

        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge CLK);
            budget++;
        end
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
